alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Sequencer for the 16-bit ALU/DECO datapath. Accepts commands over a valid/ready handshake, owns the RA/RB operand registers, drives the 3-bit `sel` into the DECO result mux, writes `outA`/`outB` back into RA/RB, and returns the new RA over a second valid/ready handshake. Sits between the instruction source (bench or future fetch unit) and the combinational ALU + DECO pair.

## Interface
- `W`, default 16: datapath width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: controller can accept a command.
- `cmd_op`, input, 4: opcode.
- `cmd_data`, input, W: load value for LDA/LDB; ignored otherwise.
- `ra`, output, W: RA register to the ALU/DECO.
- `rb`, output, W: RB register to the ALU/DECO.
- `sel`, output, 3: DECO select, registered.
- `out_a`, input, W: DECO outA.
- `out_b`, input, W: DECO outB.
- `res_valid`, output, 1: result present.
- `res_ready`, input, 1: consumer takes the result.
- `res_data`, output, W: RA after write-back.
- `err`, output, 1: one-cycle pulse on an illegal opcode.
- `busy`, output, 1: high whenever state is not IDLE.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SHR, 6 MOV, 7 EXCH: ALU ops, with `sel = cmd_op[2:0]`.
  - 8 LDA: `RA <= cmd_data`.
  - 9 LDB: `RB <= cmd_data`.
  - 10 NOP.
  - 11–15: illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready = 1`. A command is accepted when `cmd_valid & cmd_ready`.
  - LDA/LDB: write the register at the accept edge and stay in IDLE. Back-to-back loads run one per cycle. No response is generated.
  - NOP: no effect and no response.
  - Illegal opcode: pulse `err` for the cycle after acceptance and stay in IDLE. No response is generated.
  - ALU op: latch `sel` and go to EXEC.
- EXEC (exactly one cycle):
  - RA/RB and `sel` are stable, so the DECO output settles combinationally.
  - At the end of the cycle, `RA <= out_a`.
  - `RB <= out_b` only when the op is EXCH; otherwise RB holds.
  - Go to RESP.
- RESP:
  - `res_valid = 1` and `res_data = RA`. Both hold stable until `res_ready`.
  - On `res_valid & res_ready`, go to IDLE.
  - `cmd_ready = 0` throughout.
- `sel` holds its last value in IDLE. It does not return to 0.
- Width rule: all registers are W bits. No carry or overflow is kept; the datapath truncates.

## Timing
- Reset values: `RA = 0`, `RB = 0`, `sel = 0`, state IDLE, `cmd_ready = 1`, `res_valid = 0`, `res_data = 0`, `err = 0`, `busy = 0`.
- Load: accepted at edge k, so `ra`/`rb` show the new value in cycle k+1.
- ALU op timing:
  - Accepted at edge k.
  - EXEC during cycle k+1.
  - `res_valid` first high in cycle k+2.
  - Minimum command-to-command spacing is 3 cycles (`res_ready` tied high).
- `res_ready` held low: stay in RESP indefinitely. `res_data` must not change and `cmd_ready` stays low.
- `res_ready` high while `res_valid` is low: no effect.
- `rst` in EXEC or RESP: IDLE at the next edge. RA/RB clear, `res_valid` drops and any pending result is discarded. Reset has priority over every handshake.
- `cmd_valid` is ignored while `cmd_ready` is low. The source must hold its command.

## Configuration
- Macro: `ALU_SEQ_FLAGS_EN`.
- Defined:
  - Adds outputs `res_zero` (1 bit, `res_data == 0`) and `res_neg` (1 bit, `res_data[W-1]`).
  - Both are registered with `res_data` and reset to 0.
  - Both are valid only while `res_valid` is high.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `alu_seq_pkg` holds:
  - Opcode constants: `OP_ADD` through `OP_EXCH`, `OP_LDA`, `OP_LDB`, `OP_NOP`.
  - State encoding: `ST_IDLE`, `ST_EXEC`, `ST_RESP`.
  - Default width constant (16).
- Sub-module `alu_seq_regs`: the RA/RB register pair.
  - Inputs: load enables and write data; RB has a separate EXCH write enable.
  - Reset: synchronous, to 0.
- The FSM and handshakes stay in `alu_seq_ctrl`.

## Test plan
- Reset mid-operation:
  - Stimulus: LDA 0x1234, then ADD with `res_ready = 0`; assert `rst` in RESP.
  - Response: next cycle `res_valid = 0`, `ra = 0`, `cmd_ready = 1`.
- Load then ADD:
  - Stimulus: LDA 0x0003, LDB 0x0004, ADD with DECO/ALU attached.
  - Response: `sel = 0` in EXEC; `res_valid` 2 cycles after accept; `res_data = 0x0007`; `rb = 0x0004`.
- EXCH:
  - Stimulus: RA = 0x00AA, RB = 0x5500, op 7.
  - Response: `res_data = 0x5500`, `rb = 0x00AA`, `sel = 7`.
- Result back-pressure:
  - Stimulus: SHR on RA = 0x8000 with `res_ready` low for 5 cycles.
  - Response: `res_data` held at 0x4000 all 5 cycles; `cmd_ready = 0`; one transfer when `res_ready` rises.
- Illegal opcode and NOP:
  - Stimulus: op 13, then op 10.
  - Response: `err` high exactly one cycle; no `res_valid`; RA/RB unchanged; `cmd_ready` stays 1.
- Flags, with `ALU_SEQ_FLAGS_EN` defined:
  - Stimulus: SUB with RA = RB = 0x0010.
  - Response: `res_data = 0`, `res_zero = 1`, `res_neg = 0`.
  - Stimulus: SUB with RA = 0, RB = 1.
  - Response: `res_data = 0xFFFF`, `res_neg = 1`.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU/DECO sequencer: opcodes, FSM states, default width.
package alu_seq_pkg;

  localparam int ALU_SEQ_W = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_EXCH = 4'd7;
  localparam logic [3:0] OP_LDA  = 4'd8;
  localparam logic [3:0] OP_LDB  = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ALU opcodes occupy 0..7 so the low three bits map straight onto the DECO select.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_EXCH);
  endfunction

endpackage

// File: rtl/alu_seq_regs.sv
// RA/RB operand register pair: command loads take priority over EXEC write-back.
module alu_seq_regs
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_a_en,
  input  logic         ld_b_en,
  input  logic [W-1:0] ld_data,
  input  logic         wb_a_en,
  input  logic [W-1:0] wb_a_data,
  input  logic         wb_b_en,
  input  logic [W-1:0] wb_b_data,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb
);

  logic [W-1:0] ra_d, ra_q;
  logic [W-1:0] rb_d, rb_q;

  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    if (ld_a_en)      ra_d = ld_data;
    else if (wb_a_en) ra_d = wb_a_data;
    if (ld_b_en)      rb_d = ld_data;
    else if (wb_b_en) rb_d = wb_b_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra = ra_q;
  assign rb = rb_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the ALU/DECO datapath: IDLE/EXEC/RESP FSM and both handshakes.
// Optional result flags (res_zero/res_neg) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb,
  output logic [2:0]   sel,
  input  logic [W-1:0] out_a,
  input  logic [W-1:0] out_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic         res_zero,
  output logic         res_neg,
`endif
  output logic         err,
  output logic         busy
);

  state_e       state_d, state_q;
  logic [2:0]   sel_d, sel_q;
  logic         err_d, err_q;
  logic [W-1:0] res_data_d, res_data_q;
  logic         ld_a_en, ld_b_en, wb_a_en, wb_b_en;
`ifdef ALU_SEQ_FLAGS_EN
  logic         res_zero_d, res_zero_q;
  logic         res_neg_d, res_neg_q;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    err_d      = 1'b0;
    res_data_d = res_data_q;
    ld_a_en    = 1'b0;
    ld_b_en    = 1'b0;
    wb_a_en    = 1'b0;
    wb_b_en    = 1'b0;
    cmd_ready  = (state_q == ST_IDLE);
    res_valid  = (state_q == ST_RESP);
`ifdef ALU_SEQ_FLAGS_EN
    res_zero_d = res_zero_q;
    res_neg_d  = res_neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_alu_op(cmd_op)) begin
            sel_d   = cmd_op[2:0];
            state_d = ST_EXEC;
          end else if (cmd_op == OP_LDA) begin
            ld_a_en = 1'b1;
          end else if (cmd_op == OP_LDB) begin
            ld_b_en = 1'b1;
          end else if (cmd_op != OP_NOP) begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // DECO output has settled on the stable RA/RB/sel; capture it at the end of EXEC.
        wb_a_en    = 1'b1;
        wb_b_en    = (sel_q == OP_EXCH[2:0]);
        res_data_d = out_a;
`ifdef ALU_SEQ_FLAGS_EN
        res_zero_d = (out_a == '0);
        res_neg_d  = out_a[W-1];
`endif
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      err_q      <= 1'b0;
      res_data_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q <= res_zero_d;
      res_neg_q  <= res_neg_d;
`endif
    end
  end

  alu_seq_regs #(.W(W)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .ld_a_en   (ld_a_en),
    .ld_b_en   (ld_b_en),
    .ld_data   (cmd_data),
    .wb_a_en   (wb_a_en),
    .wb_a_data (out_a),
    .wb_b_en   (wb_b_en),
    .wb_b_data (out_b),
    .ra        (ra),
    .rb        (rb)
  );

  assign sel      = sel_q;
  assign err      = err_q;
  assign res_data = res_data_q;
  assign busy     = (state_q != ST_IDLE);
`ifdef ALU_SEQ_FLAGS_EN
  assign res_zero = res_zero_q;
  assign res_neg  = res_neg_q;
`endif

endmodule
